// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin writeback arbiter for a single-ported VRF bank with read priority and anti-starvation
module vrf_wb_arbiter #(
    parameter int NrPorts   = 3,
    parameter int AddrWidth = 6,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 3,
    parameter int MaxStall  = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrPorts-1:0]                wb_valid_i,
    input  logic [NrPorts*AddrWidth-1:0]      wb_addr_i,
    input  logic [NrPorts*DataWidth-1:0]      wb_data_i,
    input  logic [NrPorts*(DataWidth/8)-1:0]  wb_strb_i,
    input  logic [NrPorts*IdWidth-1:0]        wb_id_i,
    output logic [NrPorts-1:0]                wb_gnt_o,
    input  logic                              rd_req_i,
    output logic                              rd_gnt_o,
    output logic                              sram_we_o,
    output logic [AddrWidth-1:0]              sram_addr_o,
    output logic [DataWidth-1:0]              sram_wdata_o,
    output logic [DataWidth/8-1:0]            sram_be_o,
    output logic                              wb_done_o,
    output logic [IdWidth-1:0]                wb_done_id_o,
    output logic [$clog2(NrPorts)-1:0]        wb_done_port_o,
    input  logic [AddrWidth-1:0]              hazard_addr_i,
    output logic                              hazard_hit_o
);
    localparam int PortWidth  = $clog2(NrPorts);
    localparam int StrbWidth  = DataWidth / 8;
    localparam int StallWidth = $clog2(MaxStall + 1);

    logic [PortWidth-1:0]  rr_ptr, winner, idx;
    logic [StallWidth-1:0] stall_cnt;
    logic [NrPorts-1:0]    win_oh;
    logic                  found, any_valid, force_wr, grant_en, rd_lose;
    logic [AddrWidth-1:0]  sel_addr, stage_addr;
    logic [DataWidth-1:0]  sel_data, stage_data;
    logic [StrbWidth-1:0]  sel_strb, stage_strb;
    logic [IdWidth-1:0]    sel_id, stage_id;
    logic [PortWidth-1:0]  stage_port;
    logic                  stage_valid;

    assign any_valid = |wb_valid_i;
    assign force_wr  = (stall_cnt == StallWidth'(MaxStall)) && any_valid;
    assign rd_gnt_o  = rd_req_i && !force_wr;
    assign grant_en  = any_valid && (!rd_req_i || force_wr);
    assign rd_lose   = any_valid && rd_req_i && !force_wr;
    assign wb_gnt_o  = grant_en ? win_oh : '0;

    // First valid port at or after rr_ptr wins; mux its fields with the one-hot winner
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        idx      = '0;
        win_oh   = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        sel_id   = '0;
        for (int i = 0; i < NrPorts; i++) begin
            idx = PortWidth'((int'(rr_ptr) + i) % NrPorts);
            if (!found && wb_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        for (int i = 0; i < NrPorts; i++) begin
            win_oh[i] = found && (winner == PortWidth'(i));
            sel_addr  = sel_addr | ({AddrWidth{win_oh[i]}} & wb_addr_i[i*AddrWidth +: AddrWidth]);
            sel_data  = sel_data | ({DataWidth{win_oh[i]}} & wb_data_i[i*DataWidth +: DataWidth]);
            sel_strb  = sel_strb | ({StrbWidth{win_oh[i]}} & wb_strb_i[i*StrbWidth +: StrbWidth]);
            sel_id    = sel_id   | ({IdWidth{win_oh[i]}}   & wb_id_i[i*IdWidth +: IdWidth]);
        end
    end

    // Round-robin pointer advances past each winner; stall counter tracks reads beating pending writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else if (grant_en) begin
            rr_ptr    <= (winner == PortWidth'(NrPorts - 1)) ? '0 : winner + 1'b1;
            stall_cnt <= '0;
        end else if (rd_lose) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Stage valid marks a write retiring this cycle; a grant during reset is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stage_valid <= 1'b0;
        else         stage_valid <= grant_en;
    end

    // Stage payload is only meaningful alongside stage_valid, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (grant_en) begin
            stage_addr <= sel_addr;
            stage_data <= sel_data;
            stage_strb <= sel_strb;
            stage_id   <= sel_id;
            stage_port <= winner;
        end
    end

    assign sram_we_o      = stage_valid && |stage_strb;
    assign sram_addr_o    = stage_addr;
    assign sram_wdata_o   = stage_data;
    assign sram_be_o      = stage_strb;
    assign wb_done_o      = stage_valid;
    assign wb_done_id_o   = stage_id;
    assign wb_done_port_o = stage_port;
    assign hazard_hit_o   = stage_valid && |stage_strb && (stage_addr == hazard_addr_i);
endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed scoreboard bench for the VRF writeback arbiter
module tb_vrf_wb_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   wb_valid;
    logic [17:0]  wb_addr;
    logic [191:0] wb_data;
    logic [23:0]  wb_strb;
    logic [8:0]   wb_id;
    logic [2:0]   wb_gnt;
    logic         rd_req, rd_gnt;
    logic         sram_we;
    logic [5:0]   sram_addr;
    logic [63:0]  sram_wdata;
    logic [7:0]   sram_be;
    logic         wb_done;
    logic [2:0]   wb_done_id;
    logic [1:0]   wb_done_port;
    logic [5:0]   hazard_addr;
    logic         hazard_hit;

    typedef struct {
        logic [5:0]  a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [2:0]  id;
        logic [1:0]  p;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    vrf_wb_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wb_strb_i(wb_strb), .wb_id_i(wb_id), .wb_gnt_o(wb_gnt),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
        .sram_be_o(sram_be), .wb_done_o(wb_done), .wb_done_id_o(wb_done_id),
        .wb_done_port_o(wb_done_port), .hazard_addr_i(hazard_addr), .hazard_hit_o(hazard_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [5:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic [2:0] id);
        wb_addr[p*6 +: 6]   = a;
        wb_data[p*64 +: 64] = d;
        wb_strb[p*8 +: 8]   = s;
        wb_id[p*3 +: 3]     = id;
    endtask

    task automatic cyc(input logic [2:0] v, input logic rd, input logic [2:0] exp_gnt, input logic exp_rd);
        exp_t e;
        int p;
        wb_valid = v;
        rd_req   = rd;
        #1;
        chk("wb_gnt", 64'(wb_gnt), 64'(exp_gnt));
        chk("rd_gnt", 64'(rd_gnt), 64'(exp_rd));
        if (exp_gnt != 3'b000) begin
            p = exp_gnt[0] ? 0 : exp_gnt[1] ? 1 : 2;
            e.a  = wb_addr[p*6 +: 6];
            e.d  = wb_data[p*64 +: 64];
            e.s  = wb_strb[p*8 +: 8];
            e.id = wb_id[p*3 +: 3];
            e.p  = 2'(p);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done", 64'(wb_done), 64'd1);
            chk("done_id", 64'(wb_done_id), 64'(e.id));
            chk("done_port", 64'(wb_done_port), 64'(e.p));
            chk("sram_we", 64'(sram_we), 64'(|e.s));
            if (e.s != 8'h00) begin
                chk("sram_addr", 64'(sram_addr), 64'(e.a));
                chk("sram_be", 64'(sram_be), 64'(e.s));
                chk("sram_wdata", sram_wdata, e.d);
            end
        end else begin
            chk("idle_done", 64'(wb_done), 64'd0);
            chk("idle_we", 64'(sram_we), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = '0;
        wb_addr = '0;
        wb_data = '0;
        wb_strb = '0;
        wb_id = '0;
        rd_req = 1'b0;
        hazard_addr = '0;
        #3;
        chk("rst_we", 64'(sram_we), 64'd0);
        chk("rst_done", 64'(wb_done), 64'd0);
        chk("rst_hazard", 64'(hazard_hit), 64'd0);
        chk("rst_gnt", 64'(wb_gnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with all ports pending, back-to-back retirement
        set_port(0, 6'd1, 64'h1111_1111_1111_1111, 8'h0F, 3'd1);
        set_port(1, 6'd2, 64'h2222_2222_2222_2222, 8'hF0, 3'd3);
        set_port(2, 6'd3, 64'h3333_3333_3333_3333, 8'h01, 3'd4);
        cyc(3'b111, 1'b0, 3'b001, 1'b0);
        cyc(3'b111, 1'b0, 3'b010, 1'b0);
        cyc(3'b111, 1'b0, 3'b100, 1'b0);
        cyc(3'b111, 1'b0, 3'b001, 1'b0);

        // Single write from port 1
        set_port(1, 6'd5, 64'h0000_0000_0000_A5A5, 8'hFF, 3'd2);
        cyc(3'b010, 1'b0, 3'b010, 1'b0);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);

        // Zero-strobe write retires without enabling the bank
        set_port(2, 6'd7, 64'h77, 8'h00, 3'd5);
        cyc(3'b100, 1'b0, 3'b100, 1'b0);
        hazard_addr = 6'd7;
        #1;
        chk("hazard_zero_strb", 64'(hazard_hit), 64'd0);

        // Read priority with starvation relief after MaxStall losses
        set_port(0, 6'd11, 64'hBEEF, 8'h03, 3'd6);
        cyc(3'b001, 1'b1, 3'b000, 1'b1);
        cyc(3'b001, 1'b1, 3'b000, 1'b1);
        cyc(3'b000, 1'b1, 3'b000, 1'b1);
        cyc(3'b001, 1'b1, 3'b000, 1'b1);
        cyc(3'b001, 1'b1, 3'b001, 1'b0);
        cyc(3'b001, 1'b1, 3'b000, 1'b1);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);

        // Hazard probe against the staged write
        set_port(0, 6'd9, 64'h9999, 8'h0F, 3'd7);
        cyc(3'b001, 1'b0, 3'b001, 1'b0);
        hazard_addr = 6'd9;
        #1;
        chk("hazard_hit", 64'(hazard_hit), 64'd1);
        hazard_addr = 6'd8;
        #1;
        chk("hazard_miss", 64'(hazard_hit), 64'd0);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);
        hazard_addr = 6'd9;
        #1;
        chk("hazard_stale", 64'(hazard_hit), 64'd0);

        // Reset while all ports are pending and a write is staged
        set_port(0, 6'd1, 64'h1111_1111_1111_1111, 8'h0F, 3'd1);
        set_port(1, 6'd2, 64'h2222_2222_2222_2222, 8'hF0, 3'd3);
        set_port(2, 6'd3, 64'h3333_3333_3333_3333, 8'h01, 3'd4);
        cyc(3'b111, 1'b0, 3'b010, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(sram_we), 64'd0);
        chk("midrst_done", 64'(wb_done), 64'd0);
        chk("midrst_hazard", 64'(hazard_hit), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_we_hold", 64'(sram_we), 64'd0);
        chk("midrst_done_hold", 64'(wb_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b111, 1'b0, 3'b001, 1'b0);
        cyc(3'b111, 1'b0, 3'b010, 1'b0);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vrf_wb_arbiter.md
VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NrPorts, 3: number of writeback sources (ALU, MUL, LSU).
- AddrWidth, 6: VRF bank word-address width.
- DataWidth, 64: VRF word width in bits.
- IdWidth, 3: instruction-id width.
- MaxStall, 3: number of consecutive read-priority losses before a write is forced.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- wb_valid_i, in, NrPorts: source p has a write pending.
- wb_addr_i, in, NrPorts x AddrWidth: write word address.
- wb_data_i, in, NrPorts x DataWidth: write data.
- wb_strb_i, in, NrPorts x DataWidth/8: byte strobes.
- wb_id_i, in, NrPorts x IdWidth: owning instruction id.
- wb_gnt_o, out, NrPorts: write accepted this cycle; the source pops on gnt.
- rd_req_i, in, 1: operand read requests the bank this cycle.
- rd_gnt_o, out, 1: read granted this cycle.
- sram_we_o, out, 1: bank write enable.
- sram_addr_o, out, AddrWidth: bank write address.
- sram_wdata_o, out, DataWidth: bank write data.
- sram_be_o, out, DataWidth/8: bank byte enables.
- wb_done_o, out, 1: a granted write has retired.
- wb_done_id_o, out, IdWidth: id of the retired write.
- wb_done_port_o, out, clog2(NrPorts): source port of the retired write.
- hazard_addr_i, in, AddrWidth: address probed by the read side.
- hazard_hit_o, out, 1: the probed address matches the staged write.

Function
REQ-003 wb_gnt_o SHALL be combinational from the same-cycle inputs and the arbiter state, and SHALL be one-hot or zero.
REQ-004 The bank SHALL be single-ported: in any cycle at most one of rd_gnt_o and |wb_gnt_o is high.
REQ-005 Read priority: rd_gnt_o = rd_req_i && !force_wr, where force_wr = (stall_cnt == MaxStall) && |wb_valid_i.
REQ-006 A write grant SHALL occur when |wb_valid_i && (!rd_req_i || force_wr).
REQ-007 Winner selection SHALL be round-robin:
- Search starts at rr_ptr and the first valid port at or after rr_ptr, with wrap-around, wins.
- On a grant, rr_ptr <= winner+1, with NrPorts-1 wrapping to 0.
- With no grant, rr_ptr holds.
REQ-008 stall_cnt (width clog2(MaxStall+1)) SHALL be updated as follows:
- +1 in each cycle where |wb_valid_i && rd_req_i && !force_wr.
- Cleared to 0 on any write grant.
- Holds otherwise.
- Never exceeds MaxStall.
REQ-009 Latency: a grant in cycle N SHALL register the winner's addr/data/strb/id/port into a stage register; sram_*_o and wb_done_* SHALL reflect it in cycle N+1 (latency 1, throughput 1 per cycle).
REQ-010 sram_we_o SHALL be 1 in cycle N+1 only if the staged strobe is nonzero; a zero-strobe write is still granted and retired (wb_done_o=1) with sram_we_o=0.
REQ-011 sram_be_o SHALL equal the staged strobe whenever sram_we_o=1.
REQ-012 wb_done_o SHALL pulse for exactly one cycle per grant, in cycle N+1, with wb_done_id_o and wb_done_port_o taken from the stage register.
REQ-013 hazard_hit_o SHALL be combinational: stage valid && staged strobe != 0 && staged addr == hazard_addr_i.
REQ-014 Back-to-back grants SHALL overwrite the stage register every cycle with no bubble and no dropped write.
REQ-015 sram_addr_o, sram_wdata_o and wb_done_id_o SHALL hold their last value when the stage is invalid; only the valid/enable bits carry meaning then.

Reset
REQ-016 When rst_ni is asserted, the following SHALL clear asynchronously and hold while reset is active:
- stage valid, sram_we_o, wb_done_o and hazard_hit_o = 0.
- rr_ptr = 0 and stall_cnt = 0.
REQ-017 A write granted in the cycle reset asserts SHALL be lost; the source is responsible for re-issue.
REQ-018 Stage data registers SHALL need no reset.

Verification
REQ-019 Single write: valid[1]=1, addr=5, data=0xA5A5, strb=0xFF, id=2 -> gnt[1]=1 the same cycle; next cycle we=1, addr=5, be=0xFF, done=1, id=2, port=1.
REQ-020 Round-robin: valid=3'b111 held for 4 cycles with no read -> grants go to ports 0,1,2,0.
REQ-021 Starvation with MaxStall=3: rd_req_i=1 and valid[0]=1 held -> rd_gnt_o=1 for 3 cycles; 4th cycle rd_gnt_o=0 and gnt[0]=1; stall_cnt returns to 0.
REQ-022 Zero strobe: valid[2] with strb=0 -> gnt[2]=1; next cycle we=0, done=1, port=2.
REQ-023 Hazard: staged addr=9 with strb nonzero, hazard_addr_i=9 -> hazard_hit_o=1; with hazard_addr_i=8 -> 0.
REQ-024 Reset mid-operation: assert rst_ni low while valid=3'b111 -> we=0, done=0, and after release the first grant goes to port 0.
